alu16_seq: RTL and testbench
============================

# alu16_seq

Sequencer that issues operations to a combinational ALU16 (74181-style, 16-bit, active-high data, active-low carries) over a valid/ready command interface and returns registered results over a valid/ready response interface. It holds ALU16 inputs stable for a programmable settle time, captures F and flags, and chains two ALU16 passes for 32-bit ("wide") operations by feeding the low half's CN16b into the high half's CNb. It sits between the datapath control logic and the ALU16 instance.

## Interface
- SETTLE, default 1: ALU16 settle cycles per pass; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_s  in  4  ALU16 function select S.
- cmd_m  in  1  mode: 1 = logic, 0 = arithmetic.
- cmd_cnb  in  1  active-low carry-in for the low (or only) pass.
- cmd_wide  in  1  1 = 32-bit operation (two passes).
- cmd_a, cmd_b  in  32  operands; narrow ops use bits [15:0].
- alu_s  out  4, alu_m  out  1, alu_cnb  out  1, alu_a  out  16, alu_b  out  16: drive ALU16 S, M, CNb, A, B.
- alu_f  in  16, alu_cn16b  in  1, alu_aebo  in  1: ALU16 F, CN16b, AEBo.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res_f  out  32  result; narrow: {16'h0000, F}.
- res_cout_b  out  1  active-low carry-out of the final pass.
- res_aeb  out  1  narrow: AEBo; wide: AND of both passes' AEBo.

## Operation
- States: IDLE, LO, HI, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch command; drive alu_* with low halves and cmd_cnb; load settle counter with SETTLE-1; go LO.
- LO: count down; on the cycle the counter is 0, capture alu_f into res_f[15:0], alu_cn16b and alu_aebo into temps. Narrow: go RESP with res_valid=1. Wide: drive alu_a/alu_b high halves, alu_cnb = captured alu_cn16b when cmd_m=0, else 1; reload counter; go HI.
- HI: count down; at 0 capture alu_f into res_f[31:16], res_cout_b = alu_cn16b, res_aeb = lo_aeb & alu_aebo; go RESP.
- RESP: res_valid=1; res_* held stable until res_valid&res_ready; then IDLE (no new command accepted in the handshake cycle).
- alu_* outputs hold last driven values outside LO/HI.
- cmd_valid ignored outside IDLE; cmd_* sampled only on the accept edge.
- Logic mode (M=1) wide: carry not propagated, high pass alu_cnb=1.

## Timing
- Reset values (after reset edge): state IDLE, cmd_ready=1, res_valid=0, res_f=0, res_cout_b=1, res_aeb=0, alu_s=0, alu_m=0, alu_cnb=1, alu_a=0, alu_b=0.
- Accept at edge E0: alu_* valid after E0.
- Narrow: res_valid high after edge E0+SETTLE.
- Wide: high-half alu_* valid after E0+SETTLE; res_valid high after E0+2·SETTLE.
- Response accepted at edge Er: res_valid=0, cmd_ready=1 after Er; earliest next accept Er+1.
- rst mid-operation (any state): in-flight command and any pending result dropped; reset values apply after that edge.
- rst together with cmd_valid: command not accepted.

## Test plan
- Narrow add, SETTLE=1: S=1001 M=0 CNb=1 A=12345 B=11938, res_ready=1 -> res_valid after E0+1, res_f=24283, res_cout_b=1.
- Narrow subtract: S=0110 M=0 CNb=0 A=12345 B=11938 -> res_f=407, res_cout_b=0.
- Wide add with carry chain, SETTLE=2: S=1001 M=0 CNb=1 A=32'h0001FFFF B=32'h00000001 -> alu_cnb=0 during HI, res_f=32'h00020000, res_cout_b=1, res_valid after E0+4.
- Logic XOR: S=0110 M=1 A=16'h3AB9 B=16'h1232 narrow -> res_f=32'h0000288B, res_aeb=0.
- Backpressure: res_ready low 5 cycles after res_valid, cmd_valid held high with new command -> res_f/res_valid stable, cmd_ready=0, second command accepted only after response handshake.
- Reset during HI of a wide op -> next cycle res_valid=0, cmd_ready=1, alu_cnb=1, alu_a=0; subsequent narrow add completes correctly.

Source files
------------

// File: rtl/alu16_seq.sv
// alu16_seq: valid/ready sequencer around a combinational 74181-style ALU16.
// Holds ALU inputs for SETTLE cycles per pass, captures F and flags, and
// chains two passes for 32-bit operations through the CN16b -> CNb carry.
module alu16_seq #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_s,
    input  logic        cmd_m,
    input  logic        cmd_cnb,
    input  logic        cmd_wide,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    output logic        alu_cnb,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_f,
    input  logic        alu_cn16b,
    input  logic        alu_aebo,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_f,
    output logic        res_cout_b,
    output logic        res_aeb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Counter reload: the pass ends on the cycle the counter reads zero.
    localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_wide;
    logic [15:0] r_a_hi;
    logic [15:0] r_b_hi;
    logic        r_lo_aeb;
    logic [3:0]  r_alu_s;
    logic        r_alu_m;
    logic        r_alu_cnb;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [31:0] r_res_f;
    logic        r_res_cout_b;
    logic        r_res_aeb;
    logic        w_cnt_zero;
    logic        w_accept;

    assign w_cnt_zero = (r_cnt == 4'd0);
    assign w_accept   = cmd_valid && cmd_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one pass for narrow ops, two for wide ops.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_LO;
            ST_LO:   if (w_cnt_zero) w_state_next = r_wide ? ST_HI : ST_RESP;
            ST_HI:   if (w_cnt_zero) w_state_next = ST_RESP;
            ST_RESP: if (res_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_RESP: res_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch command, drive ALU, count settle time, capture results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 4'd0;
            r_wide       <= 1'b0;
            r_a_hi       <= 16'h0000;
            r_b_hi       <= 16'h0000;
            r_lo_aeb     <= 1'b0;
            r_alu_s      <= 4'd0;
            r_alu_m      <= 1'b0;
            r_alu_cnb    <= 1'b1;
            r_alu_a      <= 16'h0000;
            r_alu_b      <= 16'h0000;
            r_res_f      <= 32'h0000_0000;
            r_res_cout_b <= 1'b1;
            r_res_aeb    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_s   <= cmd_s;
                        r_alu_m   <= cmd_m;
                        r_alu_cnb <= cmd_cnb;
                        r_alu_a   <= cmd_a[15:0];
                        r_alu_b   <= cmd_b[15:0];
                        r_a_hi    <= cmd_a[31:16];
                        r_b_hi    <= cmd_b[31:16];
                        r_wide    <= cmd_wide;
                        r_cnt     <= LP_RELOAD;
                    end
                end
                ST_LO: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_res_f[15:0]  <= alu_f;
                        r_res_f[31:16] <= 16'h0000;
                        if (r_wide) begin
                            // Logic mode has no carry chain; the high pass runs with CNb inactive.
                            r_lo_aeb  <= alu_aebo;
                            r_alu_a   <= r_a_hi;
                            r_alu_b   <= r_b_hi;
                            r_alu_cnb <= r_alu_m ? 1'b1 : alu_cn16b;
                            r_cnt     <= LP_RELOAD;
                        end else begin
                            r_res_cout_b <= alu_cn16b;
                            r_res_aeb    <= alu_aebo;
                        end
                    end
                end
                ST_HI: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_res_f[31:16] <= alu_f;
                        r_res_cout_b   <= alu_cn16b;
                        r_res_aeb      <= r_lo_aeb & alu_aebo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_s      = r_alu_s;
    assign alu_m      = r_alu_m;
    assign alu_cnb    = r_alu_cnb;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign res_f      = r_res_f;
    assign res_cout_b = r_res_cout_b;
    assign res_aeb    = r_res_aeb;

endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed bench for alu16_seq. Two instances (SETTLE=1 and
// SETTLE=2) each drive a behavioural 74181-style ALU16; sel picks the target.
module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        cmd_valid;
    logic [3:0]  cmd_s;
    logic        cmd_m;
    logic        cmd_cnb;
    logic        cmd_wide;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_ready;

    logic        d1_cmd_ready, d2_cmd_ready;
    logic [3:0]  d1_alu_s, d2_alu_s;
    logic        d1_alu_m, d2_alu_m;
    logic        d1_alu_cnb, d2_alu_cnb;
    logic [15:0] d1_alu_a, d2_alu_a, d1_alu_b, d2_alu_b;
    logic [15:0] d1_alu_f, d2_alu_f;
    logic        d1_alu_cn16b, d2_alu_cn16b, d1_alu_aebo, d2_alu_aebo;
    logic        d1_res_valid, d2_res_valid;
    logic [31:0] d1_res_f, d2_res_f;
    logic        d1_res_cout_b, d2_res_cout_b, d1_res_aeb, d2_res_aeb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ALU16 model: returns {AEBo, CN16b, F}.
    function automatic logic [17:0] alu181(input logic [3:0] s, input logic m,
                                           input logic cnb, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] t_or, t_and, f;
        logic [16:0] sum;
        t_or  = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
        t_and = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
        sum   = {1'b0, t_or} + {1'b0, t_and} + {16'h0000, ~cnb};
        f     = m ? ~(t_or ^ t_and) : sum[15:0];
        return {(&f), ~sum[16], f};
    endfunction

    always_comb {d1_alu_aebo, d1_alu_cn16b, d1_alu_f} = alu181(d1_alu_s, d1_alu_m, d1_alu_cnb, d1_alu_a, d1_alu_b);
    always_comb {d2_alu_aebo, d2_alu_cn16b, d2_alu_f} = alu181(d2_alu_s, d2_alu_m, d2_alu_cnb, d2_alu_a, d2_alu_b);

    wire        res_valid  = sel ? d2_res_valid  : d1_res_valid;
    wire        cmd_ready  = sel ? d2_cmd_ready  : d1_cmd_ready;
    wire [31:0] res_f      = sel ? d2_res_f      : d1_res_f;
    wire        res_cout_b = sel ? d2_res_cout_b : d1_res_cout_b;
    wire        res_aeb    = sel ? d2_res_aeb    : d1_res_aeb;
    wire        alu_cnb    = sel ? d2_alu_cnb    : d1_alu_cnb;
    wire [15:0] alu_a      = sel ? d2_alu_a      : d1_alu_a;

    alu16_seq #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(d1_cmd_ready),
        .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cnb(cmd_cnb), .cmd_wide(cmd_wide),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_s(d1_alu_s), .alu_m(d1_alu_m), .alu_cnb(d1_alu_cnb), .alu_a(d1_alu_a), .alu_b(d1_alu_b),
        .alu_f(d1_alu_f), .alu_cn16b(d1_alu_cn16b), .alu_aebo(d1_alu_aebo),
        .res_valid(d1_res_valid), .res_ready(res_ready & ~sel), .res_f(d1_res_f),
        .res_cout_b(d1_res_cout_b), .res_aeb(d1_res_aeb)
    );

    alu16_seq #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(d2_cmd_ready),
        .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cnb(cmd_cnb), .cmd_wide(cmd_wide),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_s(d2_alu_s), .alu_m(d2_alu_m), .alu_cnb(d2_alu_cnb), .alu_a(d2_alu_a), .alu_b(d2_alu_b),
        .alu_f(d2_alu_f), .alu_cn16b(d2_alu_cn16b), .alu_aebo(d2_alu_aebo),
        .res_valid(d2_res_valid), .res_ready(res_ready & sel), .res_f(d2_res_f),
        .res_cout_b(d2_res_cout_b), .res_aeb(d2_res_aeb)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [3:0] s, input logic m, input logic cnb,
                           input logic wide, input logic [31:0] a, input logic [31:0] b);
        cmd_s = s; cmd_m = m; cmd_cnb = cnb; cmd_wide = wide; cmd_a = a; cmd_b = b;
    endtask

    // Full transaction: accept, wait for result (bounded), check, handshake.
    task automatic do_op(input string tag, input logic [3:0] s, input logic m,
                         input logic cnb, input logic wide, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_f,
                         input logic exp_cout, input logic exp_aeb, input int exp_lat,
                         input int hi_at, input logic exp_hi_cnb);
        int lat;
        logic hi_cnb;
        hi_cnb = 1'bx;
        @(posedge clk); #1;
        set_cmd(s, m, cnb, wide, a, b);
        cmd_valid = 1'b1;
        check_val({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == hi_at) hi_cnb = alu_cnb;
        end
        check_val({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        if (wide) check_val({tag, ".hi_cnb"}, 32'(hi_cnb), 32'(exp_hi_cnb));
        check_val({tag, ".res_f"}, res_f, exp_f);
        check_val({tag, ".res_cout_b"}, 32'(res_cout_b), 32'(exp_cout));
        check_val({tag, ".res_aeb"}, 32'(res_aeb), 32'(exp_aeb));
        $display("txn %s: a=%h b=%h f=%h cout_b=%0d aeb=%0d lat=%0d", tag, a, b, res_f, res_cout_b, res_aeb, lat);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_val({tag, ".post_valid"}, 32'(res_valid), 32'd0);
        check_val({tag, ".post_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        set_cmd(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check_val("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst.res_valid", 32'(res_valid), 32'd0);
        check_val("rst.res_f", res_f, 32'd0);
        check_val("rst.res_cout_b", 32'(res_cout_b), 32'd1);
        check_val("rst.alu_cnb", 32'(alu_cnb), 32'd1);
        // Command presented together with reset must not be taken.
        set_cmd(4'b1001, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0001);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        check_val("rstcmd.alu_a", 32'(alu_a), 32'd0);
        check_val("rstcmd.cmd_ready", 32'(cmd_ready), 32'd1);
        $display("txn rst_with_cmd: alu_a=%h cmd_ready=%0d", alu_a, cmd_ready);

        // SETTLE=1 instance
        sel = 1'b0;
        do_op("add", 4'b1001, 1'b0, 1'b1, 1'b0, 32'd12345, 32'd11938, 32'd24283, 1'b1, 1'b0, 1, 0, 1'b1);
        do_op("sub", 4'b0110, 1'b0, 1'b0, 1'b0, 32'd12345, 32'd11938, 32'd407, 1'b0, 1'b0, 1, 0, 1'b1);
        do_op("xor", 4'b0110, 1'b1, 1'b1, 1'b0, 32'h0000_3AB9, 32'h0000_1232, 32'h0000_288B, 1'b0, 1'b0, 1, 0, 1'b1);

        // Backpressure: result held while a second command waits.
        @(posedge clk); #1;
        set_cmd(4'b1001, 1'b0, 1'b1, 1'b0, 32'd100, 32'd23);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        set_cmd(4'b0110, 1'b0, 1'b0, 1'b0, 32'd12345, 32'd11938);
        @(posedge clk); #1;
        check_val("bp.first_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp.hold_valid", 32'(res_valid), 32'd1);
            check_val("bp.hold_f", res_f, 32'd123);
            check_val("bp.hold_ready", 32'(cmd_ready), 32'd0);
        end
        $display("txn bp_first: f=%h held 5 cycles", res_f);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_val("bp.hs_valid", 32'(res_valid), 32'd0);
        check_val("bp.hs_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_val("bp.second_accepted", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check_val("bp.second_valid", 32'(res_valid), 32'd1);
        check_val("bp.second_f", res_f, 32'd407);
        check_val("bp.second_cout", 32'(res_cout_b), 32'd0);
        $display("txn bp_second: f=%h cout_b=%0d", res_f, res_cout_b);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // SETTLE=2 instance
        sel = 1'b1;
        do_op("wide_add", 4'b1001, 1'b0, 1'b1, 1'b1, 32'h0001_FFFF, 32'h0000_0001, 32'h0002_0000, 1'b1, 1'b0, 4, 2, 1'b0);
        do_op("wide_xor", 4'b0110, 1'b1, 1'b0, 1'b1, 32'h1234_FFFF, 32'hEDCB_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 4, 2, 1'b1);

        // Reset while the high pass is in progress.
        @(posedge clk); #1;
        set_cmd(4'b1001, 1'b0, 1'b1, 1'b1, 32'h0001_FFFF, 32'h0000_0001);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rsthi.in_hi_cnb", 32'(alu_cnb), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rsthi.res_valid", 32'(res_valid), 32'd0);
        check_val("rsthi.cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rsthi.alu_cnb", 32'(alu_cnb), 32'd1);
        check_val("rsthi.alu_a", 32'(alu_a), 32'd0);
        $display("txn reset_in_hi: res_valid=%0d cmd_ready=%0d", res_valid, cmd_ready);
        do_op("add_after_rst", 4'b1001, 1'b0, 1'b1, 1'b0, 32'd12345, 32'd11938, 32'd24283, 1'b1, 1'b0, 2, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
